// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder slice processes operands LSB first, one bit per clock.
// Optional signed overflow output is enabled by defining SERIAL_ADDER_OVERFLOW_EN.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inStart,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             inCarry,
    output logic             outBusy,
    output logic             outDone,
    output logic [WIDTH-1:0] outSum,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    output logic             outOverflow,
`endif
    output logic             outCarry
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             sliceSum, sliceCarry;

    full_adder u_slice (
        .a_i (aShift_q[0]),
        .b_i (bShift_q[0]),
        .c_i (carry_q),
        .s_o (sliceSum),
        .c_o (sliceCarry)
    );

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic msbCarry_q, msbCarry_d;
`endif

    // Sum bits enter at the MSB end so the result is aligned after WIDTH shifts.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        msbCarry_d = msbCarry_q;
`endif
        case (state_q)
            RUN: begin
                aShift_d = aShift_q >> 1;
                bShift_d = bShift_q >> 1;
                sum_d    = {sliceSum, sum_q[WIDTH-1:1]};
                carry_d  = sliceCarry;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    count_d = '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    msbCarry_d = carry_q;
`endif
                end
            end
            default: begin
                if (inStart) begin
                    aShift_d = inA;
                    bShift_d = inB;
                    carry_d  = inCarry;
                    count_d  = '0;
                    state_d  = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            aShift_q <= '0;
            bShift_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            msbCarry_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            msbCarry_q <= msbCarry_d;
`endif
        end
    end

    // After the last RUN edge the carry flop holds the carry out of the MSB.
    assign outBusy  = (state_q == RUN);
    assign outDone  = (state_q == DONE);
    assign outSum   = sum_q;
    assign outCarry = carry_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign outOverflow = msbCarry_q ^ carry_q;
`endif
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: inStart  input  1  request to begin an addition.
REQ-005 SHALL have port: inA  input  WIDTH  operand A, sampled only on accepted start.
REQ-006 SHALL have port: inB  input  WIDTH  operand B, sampled only on accepted start.
REQ-007 SHALL have port: inCarry  input  1  carry-in, sampled only on accepted start.
REQ-008 SHALL have port: outBusy  output  1  high while bits are being processed.
REQ-009 SHALL have port: outDone  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port: outSum  output  WIDTH  result, A+B+carry-in, modulo 2^WIDTH.
REQ-011 SHALL have port: outCarry  output  1  carry out of bit WIDTH-1.
REQ-012 SHALL have port: outOverflow  output  1  signed two's-complement overflow (present only with macro, REQ-030).

Function
REQ-013 SHALL compute the sum bit-serially, LSB first, one bit per clock, using a single full_adder instance as the bit slice.
REQ-014 SHALL hold a carry flip-flop feeding the slice's carry input; the slice carry output SHALL be registered each RUN cycle.
REQ-015 SHALL implement states IDLE, RUN, DONE; encoding free.
REQ-016 In IDLE or DONE, inStart=1 at edge k SHALL be accepted: latch inA, inB into shift registers, load carry flip-flop with inCarry, clear bit counter, enter RUN.
REQ-017 In RUN, edges k+1..k+WIDTH SHALL each consume one bit of A and B, shift in one sum bit, and update carry; counter SHALL increment from 0 to WIDTH-1.
REQ-018 At edge k+WIDTH, state SHALL go RUN->DONE; outSum/outCarry SHALL be final in the following cycle.
REQ-019 outBusy SHALL be 1 exactly in RUN (WIDTH cycles); outDone SHALL be 1 exactly in DONE (one cycle).
REQ-020 From DONE, next edge SHALL go to IDLE unless inStart=1 (REQ-016, back-to-back accepted; no dead cycle).
REQ-021 inStart in RUN SHALL be ignored; operands and carry SHALL be unaffected.
REQ-022 outSum and outCarry SHALL hold the last result in IDLE until the next accepted start; during RUN their values are don't-care for consumers but SHALL not be X.
REQ-023 inA/inB/inCarry changes after acceptance SHALL not affect the current result.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, counter=0, carry flip-flop=0, outSum=0, outCarry=0, outBusy=0, outDone=0, outOverflow=0 (if present).
REQ-025 rst SHALL take priority over inStart and over an operation in progress; an aborted operation SHALL produce no outDone pulse.
REQ-026 First inStart accepted SHALL be the one sampled at the first edge with rst=0.

Configuration
REQ-027 Macro SERIAL_ADDER_OVERFLOW_EN SHALL control signed overflow detection.
REQ-028 With macro defined, module SHALL register the carry into bit WIDTH-1 during the last RUN cycle.
REQ-029 With macro defined, outOverflow SHALL equal (carry into MSB) XOR outCarry, valid and held under the same rules as outSum.
REQ-030 Without macro, port outOverflow and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 WIDTH=8, rst then start inA=0x5A inB=0x33 inCarry=0 -> outBusy 8 cycles, outDone in cycle 9 after start, outSum=0x8D, outCarry=0.
REQ-032 start inA=0xFF inB=0x01 inCarry=0 -> outSum=0x00, outCarry=1; inA=0x00 inB=0x00 inCarry=1 -> outSum=0x01, outCarry=0.
REQ-033 With SERIAL_ADDER_OVERFLOW_EN: 0x7F+0x01 -> outOverflow=1, 0x80; 0xFF+0x01 -> outOverflow=0, outCarry=1.
REQ-034 start 0x10+0x20, pulse inStart with 0xAA/0x55 during cycle 3 of RUN and change inA/inB -> result 0x30, single outDone.
REQ-035 assert rst in cycle 4 of RUN -> next cycle all outputs 0, state IDLE, no outDone; fresh start 0x01+0x02 -> 0x03.
REQ-036 hold inStart=1 in DONE with new operands 0x0F+0x01 -> RUN entered next edge, outBusy immediately, second outDone 9 cycles later with outSum=0x10.
